// File: rtl/stream_mux_n_1.sv
// N-to-1 valid/ready stream mux with a registered output, round-robin or manual selection.
// Build option: define STREAM_MUX_FIXED_PRIO_EN to make mode=0 a fixed lowest-index-wins priority.
module stream_mux_n_1 #(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic             load;
    logic             found;
    logic             xfer;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;

`ifndef STREAM_MUX_FIXED_PRIO_EN
    logic [SELW-1:0]  last;
`endif

    always_comb begin
        found = 1'b0;
        grant = '0;
        if (mode) begin
            // sel values at or above N match no channel, so nothing is granted
            for (int i = 0; i < N; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    found = 1'b1;
                    grant = SELW'(i);
                end
            end
        end else begin
`ifdef STREAM_MUX_FIXED_PRIO_EN
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    found = 1'b1;
                    grant = SELW'(i);
                end
            end
`else
            // Walk farthest-first so the channel nearest after last is written last and wins
            for (int k = N; k >= 1; k--) begin
                for (int i = 0; i < N; i++) begin
                    if ((int'(last) + k) % N == i && in_valid[i]) begin
                        found = 1'b1;
                        grant = SELW'(i);
                    end
                end
            end
`endif
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign load = !out_valid || out_ready;
    assign xfer = load && found && !rst;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = xfer && (grant == SELW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
`ifndef STREAM_MUX_FIXED_PRIO_EN
            last      <= SELW'(N - 1);
`endif
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant;
`ifndef STREAM_MUX_FIXED_PRIO_EN
                if (!mode) last <= grant;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Randomised and directed bench for stream_mux_n_1: a 4-channel and a 3-channel instance
// share stimulus and are compared against a transaction-level reference model.
module tb_stream_mux_n_1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        mode;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0]  rdy0;
    logic        ov0;
    logic [7:0]  od0;
    logic [1:0]  os0;
    logic [2:0]  rdy1;
    logic        ov1;
    logic [7:0]  od1;
    logic [1:0]  os1;

    int errors = 0;
    int checks = 0;

    int m_v[2];
    int m_d[2];
    int m_s[2];
    int m_last[2];

    always #5 clk = ~clk;

    stream_mux_n_1 #(.N(4), .WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .mode(mode), .sel(sel), .out_valid(ov0), .out_data(od0), .out_sel(os0),
        .out_ready(out_ready)
    );

    stream_mux_n_1 #(.N(3), .WIDTH(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2:0]), .in_data(in_data[23:0]), .in_ready(rdy1),
        .mode(mode), .sel(sel), .out_valid(ov1), .out_data(od1), .out_sel(os1),
        .out_ready(out_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    // Channel chosen by the arbitration rules, or -1 when nothing is eligible.
    function automatic int model_grant(input int n, input int last, input bit md,
                                       input int s, input logic [3:0] v);
        if (md) return (s < n && v[s]) ? s : -1;
`ifdef STREAM_MUX_FIXED_PRIO_EN
        for (int i = 0; i < n; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= n; k++) if (v[(last + k) % n]) return (last + k) % n;
`endif
        return -1;
    endfunction

    task automatic model_reset(input int d);
        m_v[d]    = 0;
        m_d[d]    = 0;
        m_s[d]    = 0;
        m_last[d] = nch(d) - 1;
    endtask

    // Runs mid-cycle: checks combinational ready, then advances the model across the edge.
    task automatic model_eval();
        for (int d = 0; d < 2; d++) begin
            int n = nch(d);
            logic [3:0] v = in_valid & 4'((1 << n) - 1);
            int g = model_grant(n, m_last[d], mode, int'(sel), v);
            bit ld = (m_v[d] == 0) || out_ready;
            int exp_rdy = (!rst && ld && g >= 0) ? (1 << g) : 0;
            check_val($sformatf("in_ready%0d", d), (d == 0) ? 32'(rdy0) : 32'(rdy1), exp_rdy);
            if (rst) begin
                model_reset(d);
            end else if (ld) begin
                if (g >= 0) begin
                    m_v[d] = 1;
                    m_d[d] = int'((in_data >> (8 * g)) & 32'hFF);
                    m_s[d] = g;
                    if (!mode) m_last[d] = g;
                end else begin
                    m_v[d] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        check_val("out_valid0", 32'(ov0), m_v[0]);
        check_val("out_data0",  32'(od0), m_d[0]);
        check_val("out_sel0",   32'(os0), m_s[0]);
        check_val("out_valid1", 32'(ov1), m_v[1]);
        check_val("out_data1",  32'(od1), m_d[1]);
        check_val("out_sel1",   32'(os1), m_s[1]);
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int rr0;
        int rr1;
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = 32'hD3D2D1D0;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;
        model_reset(0);
        model_reset(1);

        reset_dut();
        check_val("rst_valid", 32'(ov0), 0);
        check_val("rst_data",  32'(od0), 0);
        check_val("rst_sel",   32'(os0), 0);
        step();
        check_val("first_grant0", 32'(os0), 0);
        check_val("first_grant1", 32'(os1), 0);

        // Manual selection; the 3-channel copy sees sel=3 as out of range
        mode = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step();
            check_val("man_data", 32'(od0), 32'hD0 + 32'(s));
            check_val("man_sel",  32'(os0), 32'(s));
            check_val("man3_valid", 32'(ov1), (s < 3) ? 1 : 0);
        end

        // Rotation with all channels valid, then with only channels 1 and 3
        mode = 1'b0;
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            step();
`ifdef STREAM_MUX_FIXED_PRIO_EN
            rr0 = 0;
            rr1 = 0;
`else
            rr0 = i % 4;
            rr1 = i % 3;
`endif
            check_val("rr_all0", 32'(os0), rr0);
            check_val("rr_all1", 32'(os1), rr1);
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef STREAM_MUX_FIXED_PRIO_EN
            rr0 = 1;
`else
            rr0 = (i % 2 == 0) ? 1 : 3;
`endif
            check_val("rr_odd", 32'(os0), rr0);
        end

        // Backpressure after one transfer
        in_valid = 4'hF;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (2) step();

        // Bubble on channel 2, then back-to-back without a bubble
        in_valid = 4'b0100; step(); check_val("bubble_a", 32'(ov0), 1);
        in_valid = 4'b0000; step(); check_val("bubble_b", 32'(ov0), 0);
        in_valid = 4'b0100; step(); check_val("bubble_c", 32'(ov0), 1);
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            step();
            check_val("b2b_valid", 32'(ov0), 1);
            check_val("b2b_data",  32'(od0), 32'(in_data[23:16]));
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            mode      = ($urandom_range(0, 3) == 0);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
